// File: rtl/key_message_buffer.sv
// Keystroke collector: builds a space-padded message from key events and locks it until the link reports completion.
// Latency: one cycle from a key_valid / send_done rising edge or clear to the registered outputs.
// Backpressure: none on keys; keys arriving while locked or with the buffer full are discarded and flagged on key_dropped.
module key_message_buffer #(
  parameter int         MAX_CHARS = 16,
  parameter logic [7:0] PAD_CHAR  = 8'h20
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               enable,
  input  logic                               key_valid,
  input  logic [7:0]                         key_ascii,
  input  logic                               send_done,
  output logic [8*MAX_CHARS-1:0]             message,
  output logic [$clog2(MAX_CHARS+1)-1:0]     length,
  output logic                               msg_ready,
  output logic                               full,
  output logic                               key_dropped
);

  localparam int LW = $clog2(MAX_CHARS + 1);
  localparam int IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_CHARS);
  localparam logic [8*MAX_CHARS-1:0] ALL_PAD = {MAX_CHARS{PAD_CHAR}};

  typedef enum logic {
    EDIT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [8*MAX_CHARS-1:0] msg_q, msg_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   rdy_q, rdy_d;
  logic                   full_q, full_d;
  logic                   drop_q, drop_d;
  logic                   kv_q, sd_q;

  logic                   key_evt, done_evt;
  logic                   is_print, is_bs, is_cr;
  logic [IW-1:0]          wr_idx, bs_idx;

  // Rising-edge events; the history flops start high so a level already
  // asserted when reset lifts is not mistaken for a fresh keystroke/completion.
  assign key_evt  = key_valid & ~kv_q;
  assign done_evt = send_done & ~sd_q;

  // Key classification.
  assign is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign is_bs    = (key_ascii == 8'h08);
  assign is_cr    = (key_ascii == 8'h0D);

  // Slot addressing: the next free slot and the last occupied slot.
  assign wr_idx = IW'(len_q);
  assign bs_idx = IW'(len_q - 1'b1);

  // Next-state and next-output decision; clear beats link completion beats keys.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    len_d   = len_q;
    rdy_d   = rdy_q;
    drop_d  = 1'b0;

    if (clear) begin
      state_d = EDIT;
      msg_d   = ALL_PAD;
      len_d   = '0;
      rdy_d   = 1'b0;
    end else if (state_q == LOCKED) begin
      if (done_evt) begin
        // Link finished: empty the buffer and reopen editing. A key arriving
        // in the same cycle is swallowed silently.
        state_d = EDIT;
        msg_d   = ALL_PAD;
        len_d   = '0;
        rdy_d   = 1'b0;
      end else if (key_evt && (is_print || is_bs || is_cr)) begin
        drop_d = 1'b1;
      end
    end else if (key_evt && enable) begin
      // EDIT: stale done_evt edges fall through here and are ignored.
      if (is_print) begin
        if (len_q < MAX_LEN) begin
          msg_d[8*int'(wr_idx) +: 8] = key_ascii;
          len_d = len_q + 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if (is_bs) begin
        if (len_q != '0) begin
          msg_d[8*int'(bs_idx) +: 8] = PAD_CHAR;
          len_d = len_q - 1'b1;
        end
      end else if (is_cr) begin
        if (len_q != '0) begin
          state_d = LOCKED;
          rdy_d   = 1'b1;
        end
      end
    end

    full_d = (len_d == MAX_LEN);
  end

  // State and output registers; clear is handled in the next-state logic so
  // the edge-history flops keep following their inputs through it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EDIT;
      msg_q   <= ALL_PAD;
      len_q   <= '0;
      rdy_q   <= 1'b0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
      kv_q    <= 1'b1;
      sd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      rdy_q   <= rdy_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      kv_q    <= key_valid;
      sd_q    <= send_done;
    end
  end

  assign message     = msg_q;
  assign length      = len_q;
  assign msg_ready   = rdy_q;
  assign full        = full_q;
  assign key_dropped = drop_q;

endmodule
